// File: rtl/tick_timer.sv
// Programmable tick timer: counts us/ms strobes and pulses `expired`, one-shot or periodic.
// Optional expiry counter output enabled by defining TICK_TIMER_EXP_CNT_EN.
module tick_timer #(
  parameter int COUNT_DW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                us_en,
  input  logic                ms_en,
  input  logic                unit_sel,
  input  logic [COUNT_DW-1:0] load_val,
  input  logic                periodic,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                expired,
  output logic [COUNT_DW-1:0] remaining
`ifdef TICK_TIMER_EXP_CNT_EN
  ,
  output logic [7:0]          exp_count
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [COUNT_DW-1:0] remaining_q, remaining_d;
  logic [COUNT_DW-1:0] reload_q, reload_d;
  logic                unit_q, unit_d;
  logic                periodic_q, periodic_d;
  logic                expired_q, expired_d;
  logic                tick;

  assign tick = unit_q ? ms_en : us_en;

  // abort beats start, start beats tick; a restart never reports an expiry
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    unit_d      = unit_q;
    periodic_d  = periodic_q;
    expired_d   = 1'b0;
    if (abort) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (start) begin
      unit_d     = unit_sel;
      periodic_d = periodic;
      reload_d   = load_val;
      if (load_val == '0) begin
        state_d     = IDLE;
        remaining_d = '0;
        expired_d   = 1'b1;
      end else begin
        state_d     = RUN;
        remaining_d = load_val;
      end
    end else if (state_q == RUN && tick) begin
      if (remaining_q > COUNT_DW'(1)) begin
        remaining_d = remaining_q - COUNT_DW'(1);
      end else begin
        expired_d = 1'b1;
        if (periodic_q) begin
          remaining_d = reload_q;
        end else begin
          remaining_d = '0;
          state_d     = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      reload_q    <= '0;
      unit_q      <= 1'b0;
      periodic_q  <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      unit_q      <= unit_d;
      periodic_q  <= periodic_d;
      expired_q   <= expired_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign expired   = expired_q;
  assign remaining = remaining_q;

`ifdef TICK_TIMER_EXP_CNT_EN
  logic [7:0] exp_count_q, exp_count_d;

  // a zero-load start clears and counts its own immediate expiry
  always_comb begin
    exp_count_d = exp_count_q;
    if (abort) begin
      exp_count_d = '0;
    end else if (start) begin
      exp_count_d = expired_d ? 8'd1 : 8'd0;
    end else if (expired_d && exp_count_q != 8'hFF) begin
      exp_count_d = exp_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_count_q <= '0;
    end else begin
      exp_count_q <= exp_count_d;
    end
  end

  assign exp_count = exp_count_q;
`endif

endmodule

// File: tb/tb_tick_timer.sv
// Directed self-checking bench for tick_timer; expected values are hand-computed per step.
// Exercises the expiry counter as well when TICK_TIMER_EXP_CNT_EN is defined.
module tb_tick_timer;

  logic        clk;
  logic        rst;
  logic        us_en;
  logic        ms_en;
  logic        unit_sel;
  logic [15:0] load_val;
  logic        periodic;
  logic        start;
  logic        abort;
  logic        busy;
  logic        expired;
  logic [15:0] remaining;
`ifdef TICK_TIMER_EXP_CNT_EN
  logic [7:0]  exp_count;
`endif

  int testCount = 0;
  int failCount = 0;

  tick_timer #(.COUNT_DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .us_en     (us_en),
    .ms_en     (ms_en),
    .unit_sel  (unit_sel),
    .load_val  (load_val),
    .periodic  (periodic),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .expired   (expired),
    .remaining (remaining)
`ifdef TICK_TIMER_EXP_CNT_EN
    ,
    .exp_count (exp_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one clock with the given single-cycle controls; outputs settle #1 after the edge
  task automatic applyStimulus(input logic s, input logic a, input logic u, input logic m);
    start = s;
    abort = a;
    us_en = u;
    ms_en = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    us_en = 1'b0;
    ms_en = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input int expBusy, input int expExp, input int expRem);
    checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
    checkOutput({tag, ".expired"}, 32'(expired), 32'(expExp));
    checkOutput({tag, ".remaining"}, 32'(remaining), 32'(expRem));
  endtask

  initial begin
    rst = 1'b1;
    us_en = 1'b0;
    ms_en = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    unit_sel = 1'b0;
    load_val = '0;
    periodic = 1'b0;

    // reset held for 3 cycles with strobes toggling
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkState("rst0", 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkState("rst1", 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkState("rst2", 0, 0, 0);
    rst = 1'b0;
    idleCycles(2);
    checkState("rstRel", 0, 0, 0);
`ifdef TICK_TIMER_EXP_CNT_EN
    checkOutput("rst.expCount", 32'(exp_count), 0);
`endif

    // one-shot on us ticks, ms strobes interleaved and ignored
    unit_sel = 1'b0; load_val = 16'd5; periodic = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkState("os.start", 1, 0, 5);
    for (int k = 1; k <= 5; k++) begin
      idleCycles(4);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("os.msIgnored", 32'(remaining), 32'(6 - k));
      idleCycles(4);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkState($sformatf("os.tick%0d", k), (k < 5) ? 1 : 0, (k == 5) ? 1 : 0, 5 - k);
    end
    idleCycles(1);
    checkState("os.after", 0, 0, 0);

    // periodic on ms ticks; input changes mid-run must not matter
    unit_sel = 1'b1; load_val = 16'd3; periodic = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkState("per.start", 1, 0, 3);
    unit_sel = 1'b0; load_val = 16'd7; periodic = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      idleCycles(1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      idleCycles(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkState($sformatf("per.tick%0d", k), 1, (k % 3 == 0) ? 1 : 0,
                 (k % 3 == 0) ? 3 : 3 - (k % 3));
    end
`ifdef TICK_TIMER_EXP_CNT_EN
    checkOutput("per.expCount", 32'(exp_count), 4);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkState("per.abort", 0, 0, 0);
`ifdef TICK_TIMER_EXP_CNT_EN
    checkOutput("per.abortCount", 32'(exp_count), 0);
`endif

    // abort coincident with terminal tick suppresses expiry
    unit_sel = 1'b0; load_val = 16'd2; periodic = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkState("ab.tick1", 1, 0, 1);
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkState("ab.abortTerm", 0, 0, 0);
    idleCycles(1);
    checkState("ab.after", 0, 0, 0);

    // abort beats a coincident start
    load_val = 16'd6;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkState("ab2.start", 1, 0, 6);
    load_val = 16'd8;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkState("ab2.abortStart", 0, 0, 0);

    // restart on the terminal tick: no expiry, new count of 10
    load_val = 16'd4;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      idleCycles(2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    end
    checkState("rs.pre", 1, 0, 1);
    idleCycles(2);
    load_val = 16'd10;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkState("rs.restart", 1, 0, 10);
    for (int k = 1; k <= 10; k++) begin
      idleCycles(2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkState($sformatf("rs.tick%0d", k), (k < 10) ? 1 : 0, (k == 10) ? 1 : 0, 10 - k);
    end

    // zero load: single immediate pulse, periodic ignored
    load_val = 16'd0; periodic = 1'b1; unit_sel = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkState("zl.start", 0, 1, 0);
`ifdef TICK_TIMER_EXP_CNT_EN
    checkOutput("zl.expCount", 32'(exp_count), 1);
`endif
    idleCycles(1);
    checkState("zl.next", 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      idleCycles(2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkState($sformatf("zl.tick%0d", k), 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
